// File: rtl/rtc_bcd_timekeeper_if.sv
// Control, time-set and display bundle between the timekeeper and its user.
// The master drives run/mode/set; the slave returns BCD digits and status pulses.
interface rtc_bcd_timekeeper_if;
  logic       run;
  logic       mode_12h;
  logic       set_en;
  logic [7:0] set_hr;
  logic [7:0] set_min;
  logic [7:0] set_sec;
  logic [3:0] hr1;
  logic [3:0] hr0;
  logic [3:0] min1;
  logic [3:0] min0;
  logic [3:0] sec1;
  logic [3:0] sec0;
  logic       pm;
  logic [3:0] ap_code;
  logic       sec_tick;
  logic       day_wrap;
  logic       set_err;

  modport master (
    output run, mode_12h, set_en, set_hr, set_min, set_sec,
    input  hr1, hr0, min1, min0, sec1, sec0, pm, ap_code, sec_tick, day_wrap, set_err
  );

  modport slave (
    input  run, mode_12h, set_en, set_hr, set_min, set_sec,
    output hr1, hr0, min1, min0, sec1, sec0, pm, ap_code, sec_tick, day_wrap, set_err
  );
endinterface

// File: rtl/rtc_bcd_timekeeper.sv
// BCD time-of-day counter: prescales Clk to one-second ticks, keeps 24h HH:MM:SS,
// accepts validated time loads and presents a 12h or 24h view with AM/PM code.
module rtc_bcd_timekeeper #(
  parameter int CLK_DIV = 50_000_000,
  parameter int DIV_W   = 26
) (
  input  logic                 Clk,
  input  logic                 reset,
  rtc_bcd_timekeeper_if.slave  bus
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  logic [DIV_W-1:0] div_r;
  logic [3:0] h1_r, h0_r, m1_r, m0_r, s1_r, s0_r;
  logic       sec_tick_r, day_wrap_r, set_err_r;

  logic [3:0] h1_n_s, h0_n_s, m1_n_s, m0_n_s, s1_n_s, s0_n_s;
  logic       wrap_s;
  logic       tick_s;
  logic       set_ok_s;
  logic [DIV_W-1:0] div_adv_s;
  logic [4:0] hr_bin_s;
  logic [4:0] hr_12_s;
  logic [3:0] hr1_s, hr0_s;
  logic       pm_s;

  // Prescaler terminal count and set-value validation
  always_comb begin
    tick_s    = bus.run && (div_r == DIV_LAST);
    set_ok_s  = bcd_valid(bus.set_hr, 8'h23) && bcd_valid(bus.set_min, 8'h59)
                && bcd_valid(bus.set_sec, 8'h59);
    if (!bus.run) begin
      div_adv_s = div_r;
    end else if (div_r == DIV_LAST) begin
      div_adv_s = DIV_ZERO;
    end else begin
      div_adv_s = div_r + DIV_ONE;
    end
  end

  // Full seconds-to-hours carry chain resolved in a single cycle
  always_comb begin
    h1_n_s = h1_r;
    h0_n_s = h0_r;
    m1_n_s = m1_r;
    m0_n_s = m0_r;
    s1_n_s = s1_r;
    s0_n_s = s0_r;
    wrap_s = 1'b0;
    if (s0_r == 4'd9) begin
      s0_n_s = 4'd0;
      if (s1_r == 4'd5) begin
        s1_n_s = 4'd0;
        if (m0_r == 4'd9) begin
          m0_n_s = 4'd0;
          if (m1_r == 4'd5) begin
            m1_n_s = 4'd0;
            if ((h1_r == 4'd2) && (h0_r == 4'd3)) begin
              h1_n_s = 4'd0;
              h0_n_s = 4'd0;
              wrap_s = 1'b1;
            end else if (h0_r == 4'd9) begin
              h1_n_s = h1_r + 4'd1;
              h0_n_s = 4'd0;
            end else begin
              h0_n_s = h0_r + 4'd1;
            end
          end else begin
            m1_n_s = m1_r + 4'd1;
          end
        end else begin
          m0_n_s = m0_r + 4'd1;
        end
      end else begin
        s1_n_s = s1_r + 4'd1;
      end
    end else begin
      s0_n_s = s0_r + 4'd1;
    end
  end

  // Time state, prescaler and one-cycle status pulses
  always_ff @(posedge Clk) begin
    if (reset) begin
      div_r      <= DIV_ZERO;
      h1_r       <= 4'd0;
      h0_r       <= 4'd0;
      m1_r       <= 4'd0;
      m0_r       <= 4'd0;
      s1_r       <= 4'd0;
      s0_r       <= 4'd0;
      sec_tick_r <= 1'b0;
      day_wrap_r <= 1'b0;
      set_err_r  <= 1'b0;
    end else if (bus.set_en) begin
      // a load (good or bad) swallows any tick landing in the same cycle
      sec_tick_r <= 1'b0;
      day_wrap_r <= 1'b0;
      set_err_r  <= !set_ok_s;
      if (set_ok_s) begin
        div_r <= DIV_ZERO;
        h1_r  <= bus.set_hr[7:4];
        h0_r  <= bus.set_hr[3:0];
        m1_r  <= bus.set_min[7:4];
        m0_r  <= bus.set_min[3:0];
        s1_r  <= bus.set_sec[7:4];
        s0_r  <= bus.set_sec[3:0];
      end else begin
        div_r <= div_adv_s;
      end
    end else begin
      div_r      <= div_adv_s;
      sec_tick_r <= tick_s;
      day_wrap_r <= tick_s && wrap_s;
      set_err_r  <= 1'b0;
      if (tick_s) begin
        h1_r <= h1_n_s;
        h0_r <= h0_n_s;
        m1_r <= m1_n_s;
        m0_r <= m0_n_s;
        s1_r <= s1_n_s;
        s0_r <= s0_n_s;
      end
    end
  end

  // Hour presentation: 24h passes through, 12h maps 00->12 and 13..23 -> 01..11
  always_comb begin
    hr_bin_s = 5'(h1_r) * 5'd10 + 5'(h0_r);
    pm_s     = ({h1_r, h0_r} >= 8'h12);
    if (hr_bin_s == 5'd0) begin
      hr_12_s = 5'd12;
    end else if (hr_bin_s > 5'd12) begin
      hr_12_s = hr_bin_s - 5'd12;
    end else begin
      hr_12_s = hr_bin_s;
    end
    if (!bus.mode_12h) begin
      hr1_s = h1_r;
      hr0_s = h0_r;
    end else if (hr_12_s >= 5'd10) begin
      hr1_s = 4'd1;
      hr0_s = 4'(hr_12_s - 5'd10);
    end else begin
      hr1_s = 4'd0;
      hr0_s = hr_12_s[3:0];
    end
  end

  assign bus.hr1      = hr1_s;
  assign bus.hr0      = hr0_s;
  assign bus.min1     = m1_r;
  assign bus.min0     = m0_r;
  assign bus.sec1     = s1_r;
  assign bus.sec0     = s0_r;
  assign bus.pm       = pm_s;
  assign bus.ap_code  = pm_s ? 4'd11 : 4'd10;
  assign bus.sec_tick = sec_tick_r;
  assign bus.day_wrap = day_wrap_r;
  assign bus.set_err  = set_err_r;

endmodule

// File: tb/tb_rtc_bcd_timekeeper.sv
// Directed bench for rtc_bcd_timekeeper at CLK_DIV=4; inputs change and outputs
// are sampled on the falling edge, expected values are hand-computed constants.
module tb_rtc_bcd_timekeeper;

  logic Clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  rtc_bcd_timekeeper_if bus ();

  rtc_bcd_timekeeper #(.CLK_DIV(4), .DIV_W(3)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] disp_time();
    return {bus.hr1, bus.hr0, bus.min1, bus.min0, bus.sec1, bus.sec0};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.set_hr  = h;
    bus.set_min = m;
    bus.set_sec = s;
    bus.set_en  = 1'b1;
    @(negedge Clk);
    bus.set_en  = 1'b0;
  endtask

  initial begin
    int pulses;
    int last_i;
    int min_gap;
    int max_gap;
    vec_cnt = 0;
    err_cnt = 0;
    reset = 1'b1;
    bus.run = 1'b0;
    bus.mode_12h = 1'b0;
    bus.set_en = 1'b0;
    bus.set_hr = 8'h00;
    bus.set_min = 8'h00;
    bus.set_sec = 8'h00;

    // 1: reset state, then one minute of counting
    cycles(2);
    check_val("rst_time24", 32'(disp_time()), 32'h000000);
    check_val("rst_pm", 32'(bus.pm), 32'd0);
    check_val("rst_ap", 32'(bus.ap_code), 32'd10);
    check_val("rst_flags", 32'({bus.sec_tick, bus.day_wrap, bus.set_err}), 32'd0);
    bus.mode_12h = 1'b1;
    #1;
    check_val("rst_time12", 32'(disp_time()), 32'h120000);
    bus.mode_12h = 1'b0;
    reset = 1'b0;
    bus.run = 1'b1;
    pulses = 0;
    last_i = 0;
    min_gap = 1000;
    max_gap = 0;
    for (int i = 1; i <= 240; i++) begin
      @(negedge Clk);
      if (bus.sec_tick) begin
        if (pulses > 0) begin
          if (i - last_i < min_gap) min_gap = i - last_i;
          if (i - last_i > max_gap) max_gap = i - last_i;
        end
        pulses++;
        last_i = i;
      end
    end
    check_val("run_1min", 32'(disp_time()), 32'h000100);
    check_val("tick_count", 32'(pulses), 32'd60);
    check_val("tick_min_gap", 32'(min_gap), 32'd4);
    check_val("tick_max_gap", 32'(max_gap), 32'd4);

    // 2: day wrap
    set_time(8'h23, 8'h59, 8'h58);
    check_val("set_2359", 32'(disp_time()), 32'h235958);
    check_val("pm_before", 32'(bus.pm), 32'd1);
    cycles(4);
    check_val("t_235959", 32'(disp_time()), 32'h235959);
    check_val("no_wrap_yet", 32'(bus.day_wrap), 32'd0);
    cycles(4);
    check_val("t_wrap", 32'(disp_time()), 32'h000000);
    check_val("day_wrap", 32'(bus.day_wrap), 32'd1);
    check_val("pm_after", 32'(bus.pm), 32'd0);
    check_val("ap_after", 32'(bus.ap_code), 32'd10);
    cycles(1);
    check_val("day_wrap_end", 32'(bus.day_wrap), 32'd0);

    // 3: 12-hour display
    bus.run = 1'b0;
    bus.mode_12h = 1'b1;
    set_time(8'h00, 8'h30, 8'h00);
    check_val("h12_0030", 32'(disp_time()), 32'h123000);
    check_val("h12_0030_ap", 32'(bus.ap_code), 32'd10);
    set_time(8'h13, 8'h05, 8'h00);
    check_val("h12_1305", 32'(disp_time()), 32'h010500);
    check_val("h12_1305_ap", 32'(bus.ap_code), 32'd11);
    bus.mode_12h = 1'b0;
    #1;
    check_val("h24_1305", 32'(disp_time()), 32'h130500);
    bus.mode_12h = 1'b1;
    set_time(8'h12, 8'h00, 8'h00);
    check_val("h12_1200", 32'(disp_time()), 32'h120000);
    check_val("h12_1200_ap", 32'(bus.ap_code), 32'd11);
    set_time(8'h23, 8'h00, 8'h00);
    check_val("h12_2300", 32'(disp_time()), 32'h110000);
    set_time(8'h11, 8'h00, 8'h00);
    check_val("h12_1100", 32'(disp_time()), 32'h110000);
    check_val("h12_1100_ap", 32'(bus.ap_code), 32'd10);
    set_time(8'h19, 8'h00, 8'h00);
    check_val("h12_1900", 32'(disp_time()), 32'h070000);
    bus.mode_12h = 1'b0;

    // 4: rejected loads
    set_time(8'h10, 8'h20, 8'h30);
    check_val("set_ok_noerr", 32'(bus.set_err), 32'd0);
    set_time(8'h24, 8'h00, 8'h00);
    check_val("err_hr24", 32'(bus.set_err), 32'd1);
    check_val("keep_hr24", 32'(disp_time()), 32'h102030);
    set_time(8'h00, 8'h5A, 8'h00);
    check_val("err_min5a", 32'(bus.set_err), 32'd1);
    check_val("keep_min5a", 32'(disp_time()), 32'h102030);
    set_time(8'h00, 8'h00, 8'h60);
    check_val("err_sec60", 32'(bus.set_err), 32'd1);
    check_val("keep_sec60", 32'(disp_time()), 32'h102030);
    set_time(8'h1A, 8'h00, 8'h00);
    check_val("err_hr1a", 32'(bus.set_err), 32'd1);
    cycles(1);
    check_val("err_end", 32'(bus.set_err), 32'd0);

    // 5: load on the tick cycle wins and restarts the prescaler
    set_time(8'h09, 8'h00, 8'h00);
    bus.run = 1'b1;
    cycles(3);
    check_val("pre_tick", 32'(disp_time()), 32'h090000);
    set_time(8'h10, 8'h00, 8'h00);
    check_val("set_on_tick", 32'(disp_time()), 32'h100000);
    check_val("no_tick_pulse", 32'(bus.sec_tick), 32'd0);
    cycles(3);
    check_val("tick_wait", 32'(disp_time()), 32'h100000);
    cycles(1);
    check_val("tick_after4", 32'(disp_time()), 32'h100001);
    check_val("tick_pulse", 32'(bus.sec_tick), 32'd1);

    // 6: hold then resume from the held prescaler; reset mid-run
    cycles(2);
    bus.run = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (bus.sec_tick) pulses++;
    end
    check_val("hold_time", 32'(disp_time()), 32'h100001);
    check_val("hold_ticks", 32'(pulses), 32'd0);
    bus.run = 1'b1;
    cycles(1);
    check_val("resume_1", 32'(disp_time()), 32'h100001);
    cycles(1);
    check_val("resume_2", 32'(disp_time()), 32'h100002);
    cycles(1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check_val("mid_reset", 32'(disp_time()), 32'h000000);
    cycles(3);
    check_val("post_rst_3", 32'(disp_time()), 32'h000000);
    cycles(1);
    check_val("post_rst_4", 32'(disp_time()), 32'h000001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
